// File: rtl/ddr3_dfi_phy_lite_if.sv
// rtl/ddr3_dfi_phy_lite_if.sv - DFI controller-side bus of the DDR3 PHY front end
interface ddr3_dfi_phy_lite_if;
  // Command and DRAM control
  logic        dfi_cs_n_i;
  logic        dfi_ras_n_i;
  logic        dfi_cas_n_i;
  logic        dfi_we_n_i;
  logic        dfi_reset_n_i;
  logic        dfi_cke_i;
  logic        dfi_odt_i;
  logic [14:0] dfi_address_i;
  logic [2:0]  dfi_bank_i;
  // Write data
  logic [31:0] dfi_wrdata_i;
  logic        dfi_wrdata_en_i;
  logic [3:0]  dfi_wrdata_mask_i;
  // Read data
  logic        dfi_rddata_en_i;
  logic [31:0] dfi_rddata_o;
  logic        dfi_rddata_valid_o;
  logic [1:0]  dfi_rddata_dnv_o;

  // Memory controller side
  modport master (
    output dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i,
    output dfi_reset_n_i, dfi_cke_i, dfi_odt_i, dfi_address_i, dfi_bank_i,
    output dfi_wrdata_i, dfi_wrdata_en_i, dfi_wrdata_mask_i, dfi_rddata_en_i,
    input  dfi_rddata_o, dfi_rddata_valid_o, dfi_rddata_dnv_o
  );

  // PHY side
  modport slave (
    input  dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i,
    input  dfi_reset_n_i, dfi_cke_i, dfi_odt_i, dfi_address_i, dfi_bank_i,
    input  dfi_wrdata_i, dfi_wrdata_en_i, dfi_wrdata_mask_i, dfi_rddata_en_i,
    output dfi_rddata_o, dfi_rddata_valid_o, dfi_rddata_dnv_o
  );
endinterface

// File: rtl/ddr3_dfi_phy_lite.sv
// rtl/ddr3_dfi_phy_lite.sv - DFI 1:1 front end: command, write alignment, read latency, IDELAY taps
module ddr3_dfi_phy_lite #(
  parameter int DQS_TAP_DELAY_INIT = 27,
  parameter int DQ_TAP_DELAY_INIT  = 0,
  parameter int TPHY_RDLAT         = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  ddr3_dfi_phy_lite_if.slave        dfi,
  output logic                      ddr3_cs_n_o,
  output logic                      ddr3_ras_n_o,
  output logic                      ddr3_cas_n_o,
  output logic                      ddr3_we_n_o,
  output logic                      ddr3_reset_n_o,
  output logic                      ddr3_cke_o,
  output logic                      ddr3_odt_o,
  output logic [2:0]                ddr3_ba_o,
  output logic [13:0]               ddr3_addr_o,
  output logic [31:0]               wr_dq_o,
  output logic [3:0]                wr_dm_o,
  output logic                      wr_oe_o,
  input  logic [31:0]               rd_dq_i,
  output logic [4:0]                dqs_tap_o,
  output logic [4:0]                dq_tap_o
);

  localparam logic [4:0] DQS_TAP_RST = 5'(DQS_TAP_DELAY_INIT);
  localparam logic [4:0] DQ_TAP_RST  = 5'(DQ_TAP_DELAY_INIT);

  // Command/control pin registers
  logic        cs_n_q, ras_n_q, cas_n_q, we_n_q;
  logic        reset_n_q, cke_q, odt_q;
  logic [2:0]  ba_q;
  logic [13:0] addr_q;

  // Write path registers
  logic [31:0] wr_dq_q, wr_dq_d;
  logic [3:0]  wr_dm_q, wr_dm_d;
  logic        wr_oe_q, wr_oe_d;

  // Read path: rd_en_sr_q[i] is the enable seen i+1 edges ago
  logic [TPHY_RDLAT-1:0] rd_en_sr_q, rd_en_sr_d;
  logic                  rd_load;
  logic [31:0]           rddata_q, rddata_d;
  logic [1:0]            dnv_q, dnv_d;

  // Tap registers
  logic [4:0] dqs_tap_q, dq_tap_q;

  // The row address is 14 bits on this part; the top DFI address bit is dropped
  logic unused_addr_msb;
  assign unused_addr_msb = dfi.dfi_address_i[14];

  // Register every command/control input once onto the pin side
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_n_q    <= 1'b1;
      ras_n_q   <= 1'b1;
      cas_n_q   <= 1'b1;
      we_n_q    <= 1'b1;
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      odt_q     <= 1'b0;
      ba_q      <= 3'd0;
      addr_q    <= 14'd0;
    end else begin
      cs_n_q    <= dfi.dfi_cs_n_i;
      ras_n_q   <= dfi.dfi_ras_n_i;
      cas_n_q   <= dfi.dfi_cas_n_i;
      we_n_q    <= dfi.dfi_we_n_i;
      reset_n_q <= dfi.dfi_reset_n_i;
      cke_q     <= dfi.dfi_cke_i;
      odt_q     <= dfi.dfi_odt_i;
      ba_q      <= dfi.dfi_bank_i;
      addr_q    <= dfi.dfi_address_i[13:0];
    end
  end

  // Write data and mask capture only on enabled cycles so the OSERDES sees stable idle values
  always_comb begin
    wr_oe_d = dfi.dfi_wrdata_en_i;
    wr_dq_d = wr_dq_q;
    wr_dm_d = wr_dm_q;
    if (dfi.dfi_wrdata_en_i) begin
      wr_dq_d = dfi.dfi_wrdata_i;
      wr_dm_d = dfi.dfi_wrdata_mask_i;
    end
  end

  // Write path registers, aligned with wr_oe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_dq_q <= 32'd0;
      wr_dm_q <= 4'd0;
      wr_oe_q <= 1'b0;
    end else begin
      wr_dq_q <= wr_dq_d;
      wr_dm_q <= wr_dm_d;
      wr_oe_q <= wr_oe_d;
    end
  end

  // Shift the read enable; the last stage's next value marks the edge that presents read data
  always_comb begin
    rd_en_sr_d[0] = dfi.dfi_rddata_en_i;
    for (int i = 1; i < TPHY_RDLAT; i++) begin
      rd_en_sr_d[i] = rd_en_sr_q[i-1];
    end
    rd_load  = rd_en_sr_d[TPHY_RDLAT-1];
    rddata_d = rd_load ? rd_dq_i : rddata_q;
    dnv_d    = {2{~rd_load}};
  end

  // Read latency pipeline and returned data; reset drops every pending read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_en_sr_q <= '0;
      rddata_q   <= 32'd0;
      dnv_q      <= 2'b11;
    end else begin
      rd_en_sr_q <= rd_en_sr_d;
      rddata_q   <= rddata_d;
      dnv_q      <= dnv_d;
    end
  end

  // IDELAY taps load their initial value on reset and are static afterwards
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dqs_tap_q <= DQS_TAP_RST;
      dq_tap_q  <= DQ_TAP_RST;
    end else begin
      dqs_tap_q <= dqs_tap_q;
      dq_tap_q  <= dq_tap_q;
    end
  end

  assign ddr3_cs_n_o    = cs_n_q;
  assign ddr3_ras_n_o   = ras_n_q;
  assign ddr3_cas_n_o   = cas_n_q;
  assign ddr3_we_n_o    = we_n_q;
  assign ddr3_reset_n_o = reset_n_q;
  assign ddr3_cke_o     = cke_q;
  assign ddr3_odt_o     = odt_q;
  assign ddr3_ba_o      = ba_q;
  assign ddr3_addr_o    = addr_q;

  assign wr_dq_o = wr_dq_q;
  assign wr_dm_o = wr_dm_q;
  assign wr_oe_o = wr_oe_q;

  assign dfi.dfi_rddata_o       = rddata_q;
  assign dfi.dfi_rddata_valid_o = rd_en_sr_q[TPHY_RDLAT-1];
  assign dfi.dfi_rddata_dnv_o   = dnv_q;

  assign dqs_tap_o = dqs_tap_q;
  assign dq_tap_o  = dq_tap_q;

endmodule

// File: tb/tb_ddr3_dfi_phy_lite.sv
// tb/tb_ddr3_dfi_phy_lite.sv - scoreboard bench for ddr3_dfi_phy_lite
module tb_ddr3_dfi_phy_lite;
  localparam int RDLAT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Cycle c spans from rising edge c to rising edge c+1
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ddr3_dfi_phy_lite_if dfi_bus ();

  logic        cs_n, ras_n, cas_n, we_n, reset_n, cke, odt;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic [31:0] wr_dq;
  logic [3:0]  wr_dm;
  logic        wr_oe;
  logic [31:0] rd_dq;
  logic [4:0]  dqs_tap, dq_tap;

  ddr3_dfi_phy_lite #(
    .DQS_TAP_DELAY_INIT(27),
    .DQ_TAP_DELAY_INIT (0),
    .TPHY_RDLAT        (RDLAT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .dfi           (dfi_bus),
    .ddr3_cs_n_o   (cs_n),
    .ddr3_ras_n_o  (ras_n),
    .ddr3_cas_n_o  (cas_n),
    .ddr3_we_n_o   (we_n),
    .ddr3_reset_n_o(reset_n),
    .ddr3_cke_o    (cke),
    .ddr3_odt_o    (odt),
    .ddr3_ba_o     (ba),
    .ddr3_addr_o   (addr),
    .wr_dq_o       (wr_dq),
    .wr_dm_o       (wr_dm),
    .wr_oe_o       (wr_oe),
    .rd_dq_i       (rd_dq),
    .dqs_tap_o     (dqs_tap),
    .dq_tap_o      (dq_tap)
  );

  typedef struct {
    int          tag;
    bit          rst;
    logic [23:0] cmd;
    logic        oe;
    logic [31:0] dq;
    logic [3:0]  dm;
  } exp_t;

  typedef struct {
    int          tag;
    logic [31:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  logic [31:0] rd_tab [0:1023];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, expv);
    end
  endtask

  // Stimulus values for the current cycle
  logic        s_rst, s_cs, s_ras, s_cas, s_we, s_resetn, s_cke, s_odt;
  logic [14:0] s_addr;
  logic [2:0]  s_ba;
  logic        s_wen, s_ren;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;

  // Reference model state: last captured write beat
  logic [31:0] hold_dq;
  logic [3:0]  hold_dm;

  // Apply this cycle's inputs, record what the pins must show later, then advance one cycle
  task automatic step();
    exp_t e;
    rd_t  r;
    rst                        = s_rst;
    dfi_bus.dfi_cs_n_i         = s_cs;
    dfi_bus.dfi_ras_n_i        = s_ras;
    dfi_bus.dfi_cas_n_i        = s_cas;
    dfi_bus.dfi_we_n_i         = s_we;
    dfi_bus.dfi_reset_n_i      = s_resetn;
    dfi_bus.dfi_cke_i          = s_cke;
    dfi_bus.dfi_odt_i          = s_odt;
    dfi_bus.dfi_address_i      = s_addr;
    dfi_bus.dfi_bank_i         = s_ba;
    dfi_bus.dfi_wrdata_i       = s_wdata;
    dfi_bus.dfi_wrdata_en_i    = s_wen;
    dfi_bus.dfi_wrdata_mask_i  = s_wmask;
    dfi_bus.dfi_rddata_en_i    = s_ren;
    rd_dq                      = rd_tab[cyc];
    e.tag = cyc + 1;
    e.rst = s_rst;
    if (s_rst) begin
      e.cmd   = {4'b1111, 1'b0, 1'b0, 1'b0, 3'd0, 14'd0};
      e.oe    = 1'b0;
      hold_dq = 32'd0;
      hold_dm = 4'd0;
      while (rd_q.size() > 0 && rd_q[$].tag > cyc) void'(rd_q.pop_back());
    end else begin
      e.cmd = {s_cs, s_ras, s_cas, s_we, s_resetn, s_cke, s_odt, s_ba, s_addr[13:0]};
      e.oe  = s_wen;
      if (s_wen) begin
        hold_dq = s_wdata;
        hold_dm = s_wmask;
      end
      if (s_ren) begin
        r.tag  = cyc + RDLAT;
        r.data = rd_tab[cyc + RDLAT - 1];
        rd_q.push_back(r);
      end
    end
    e.dq = hold_dq;
    e.dm = hold_dm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the scoreboard in the middle of every cycle
  exp_t        me;
  rd_t         mr;
  bit          mon_on  = 1'b0;
  logic [31:0] last_rd = 32'd0;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      me = exp_q.pop_front();
      chk("cmd", 64'({cs_n, ras_n, cas_n, we_n, reset_n, cke, odt, ba, addr}), 64'(me.cmd));
      chk("wr_oe", 64'(wr_oe), 64'(me.oe));
      chk("wr_dq", 64'(wr_dq), 64'(me.dq));
      chk("wr_dm", 64'(wr_dm), 64'(me.dm));
      chk("taps", 64'({dqs_tap, dq_tap}), 64'({5'd27, 5'd0}));
      if (me.rst) begin
        last_rd = 32'd0;
        mon_on  = 1'b1;
      end
    end
    if (rd_q.size() > 0 && rd_q[0].tag == cyc) begin
      mr = rd_q.pop_front();
      chk("rd_valid", 64'(dfi_bus.dfi_rddata_valid_o), 64'd1);
      chk("rd_data", 64'(dfi_bus.dfi_rddata_o), 64'(mr.data));
      chk("rd_dnv", 64'(dfi_bus.dfi_rddata_dnv_o), 64'd0);
      last_rd = mr.data;
    end else if (mon_on) begin
      chk("rd_idle_valid", 64'(dfi_bus.dfi_rddata_valid_o), 64'd0);
      chk("rd_idle_dnv", 64'(dfi_bus.dfi_rddata_dnv_o), 64'd3);
      chk("rd_hold", 64'(dfi_bus.dfi_rddata_o), 64'(last_rd));
    end
  end

  task automatic idle(input int n);
    s_cs = 1'b1; s_ras = 1'b1; s_cas = 1'b1; s_we = 1'b1;
    s_wen = 1'b0; s_ren = 1'b0;
    repeat (n) step();
  endtask

  logic [31:0] wd [4] = '{32'h00001111, 32'h22223333, 32'h44445555, 32'h66667777};

  initial begin
    for (int i = 0; i < 1024; i++) rd_tab[i] = (i < 200) ? 32'hCAFE0000 + 32'(i) : $urandom;
    s_rst = 1'b1; s_resetn = 1'b1; s_cke = 1'b1; s_odt = 1'b0;
    s_addr = 15'd0; s_ba = 3'd0; s_wdata = 32'd0; s_wmask = 4'd0;
    hold_dq = 32'd0; hold_dm = 4'd0;

    // Power-up reset
    idle(3);
    s_rst = 1'b0;
    idle(2);

    // ACT to bank 2, row 0x04D2; then an address with bit 14 set
    s_cs = 1'b0; s_ras = 1'b0; s_cas = 1'b1; s_we = 1'b1; s_ba = 3'd2; s_addr = 15'h04D2;
    step();
    idle(1);
    s_cs = 1'b0; s_ras = 1'b1; s_cas = 1'b0; s_we = 1'b1; s_addr = 15'h4001;
    step();
    idle(1);

    // Four back-to-back write beats
    s_wmask = 4'd0;
    for (int i = 0; i < 4; i++) begin
      s_wen = 1'b1; s_wdata = wd[i];
      step();
    end
    idle(2);

    // Single read, then a four-cycle burst read
    s_ren = 1'b1;
    step();
    idle(7);
    for (int i = 0; i < 4; i++) begin
      s_ren = 1'b1;
      step();
    end
    idle(8);

    // Reset two cycles after a read is issued, with write traffic in flight
    s_ren = 1'b1; s_wen = 1'b1; s_wdata = 32'hA5A5_5A5A; s_wmask = 4'b0101;
    step();
    idle(1);
    s_rst = 1'b1;
    idle(3);
    s_rst = 1'b0;
    idle(8);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      s_rst    = ($urandom_range(0, 59) == 0);
      s_cs     = 1'($urandom_range(0, 1));
      s_ras    = 1'($urandom_range(0, 1));
      s_cas    = 1'($urandom_range(0, 1));
      s_we     = 1'($urandom_range(0, 1));
      s_resetn = 1'($urandom_range(0, 1));
      s_cke    = 1'($urandom_range(0, 1));
      s_odt    = 1'($urandom_range(0, 1));
      s_addr   = 15'($urandom);
      s_ba     = 3'($urandom);
      s_wen    = 1'($urandom_range(0, 1));
      s_wdata  = $urandom;
      s_wmask  = 4'($urandom);
      s_ren    = ($urandom_range(0, 2) != 0);
      step();
    end
    s_rst = 1'b0;
    idle(RDLAT + 5);

    @(negedge clk);
    #1;
    chk("pending_reads", 64'(rd_q.size()), 64'd0);
    chk("pending_cycles", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
